pipeline_mem: RTL and testbench

Memory-access stage of the in-order RISC-V pipeline, directly downstream of the execute stage. It consumes the execute stage's result, store data, destination register, memory opcode/size and ecall flag, and performs at most one data-memory load or store per instruction over a valid/ready request and response interface. It aligns and sign- or zero-extends load data, then presents one result per instruction to write-back. Its `ready` output drives the execute stage's `next_stage_ready`.

---
 rtl/pipeline_pkg.sv | 44 ++++
 rtl/mem_load_align.sv | 40 ++++
 rtl/pipeline_mem.sv | 161 ++++++++++++++++
 tb/tb_pipeline_mem.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants, state encoding and alignment helpers for the memory-access stage.
package pipeline_pkg;

   localparam logic [31:0] MEM_NONE  = 32'd0;
   localparam logic [31:0] MEM_LOAD  = 32'd1;
   localparam logic [31:0] MEM_STORE = 32'd2;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mem_state_t;

   function automatic logic is_misaligned(input logic [2:0] lane, input logic [1:0] log2_bytes);
      logic mis_s;
      case (log2_bytes)
         SIZE_B:  mis_s = 1'b0;
         SIZE_H:  mis_s = lane[0];
         SIZE_W:  mis_s = |lane[1:0];
         SIZE_D:  mis_s = |lane;
         default: mis_s = 1'b0;
      endcase
      return mis_s;
   endfunction

   function automatic logic [7:0] lane_mask(input logic [1:0] log2_bytes, input logic [2:0] lane);
      logic [7:0] mask_s;
      case (log2_bytes)
         SIZE_B:  mask_s = 8'h01;
         SIZE_H:  mask_s = 8'h03;
         SIZE_W:  mask_s = 8'h0F;
         SIZE_D:  mask_s = 8'hFF;
         default: mask_s = 8'h00;
      endcase
      return mask_s << lane;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: selects the accessed bytes from an aligned 64-bit word
// and sign- or zero-extends them to the register width.
module mem_load_align
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] resp_data,
   input  logic [2:0]            lane,
   input  logic [2:0]            size,
   output logic [DATA_WIDTH-1:0] result
);

   logic [DATA_WIDTH-1:0] shifted_s;
   logic                  sign_s;

   // Shift the addressed lane down to bit 0, then extend per size and signedness.
   always_comb begin
      shifted_s = resp_data >> {lane, 3'b000};
      sign_s    = 1'b0;
      result    = '0;
      case (size[1:0])
         SIZE_B: begin
            sign_s = ~size[2] & shifted_s[7];
            result = {{(DATA_WIDTH-8){sign_s}}, shifted_s[7:0]};
         end
         SIZE_H: begin
            sign_s = ~size[2] & shifted_s[15];
            result = {{(DATA_WIDTH-16){sign_s}}, shifted_s[15:0]};
         end
         SIZE_W: begin
            sign_s = ~size[2] & shifted_s[31];
            result = {{(DATA_WIDTH-32){sign_s}}, shifted_s[31:0]};
         end
         SIZE_D:  result = shifted_s;
         default: result = shifted_s;
      endcase
   end

endmodule

// File: rtl/pipeline_mem.sv
// Memory-access pipeline stage: one load/store per instruction over valid/ready
// data-memory channels, presenting one result per instruction to write-back.
module pipeline_mem
   import pipeline_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   output logic                  ready,
   input  logic [DATA_WIDTH-1:0] ex_res,
   input  logic [DATA_WIDTH-1:0] r2_val_mem,
   input  logic [4:0]            mem_dst_reg,
   input  logic [31:0]           mem_opcode,
   input  logic [2:0]            mem_operation_size,
   input  logic                  ecall_mem,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic [ADDR_WIDTH-1:0] dmem_req_addr,
   output logic                  dmem_req_write,
   output logic [DATA_WIDTH-1:0] dmem_req_wdata,
   output logic [7:0]            dmem_req_wstrb,
   input  logic                  dmem_resp_valid,
   input  logic [DATA_WIDTH-1:0] dmem_resp_data,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [4:0]            wb_dst_reg,
   output logic                  wb_ecall,
   output logic                  wb_misaligned
);

   mem_state_t            state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [2:0]            size_r;
   logic                  is_store_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [7:0]            wstrb_r;
   logic [DATA_WIDTH-1:0] wb_data_r;
   logic [4:0]            wb_dst_r;
   logic                  wb_ecall_r;
   logic                  wb_mis_r;

   logic                  ready_s;
   logic                  accept_s;
   logic                  is_load_s;
   logic                  is_store_s;
   logic                  is_mem_s;
   logic                  mis_s;
   logic [DATA_WIDTH-1:0] load_result_s;

   assign ready_s    = (state_r == ST_IDLE) || ((state_r == ST_DONE) && wb_ready);
   assign accept_s   = ex_valid && ready_s;
   assign is_load_s  = (mem_opcode == MEM_LOAD);
   assign is_store_s = (mem_opcode == MEM_STORE);
   assign is_mem_s   = is_load_s || is_store_s;
   assign mis_s      = is_mem_s && is_misaligned(ex_res[2:0], mem_operation_size[1:0]);

   mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .resp_data (dmem_resp_data),
      .lane      (addr_r[2:0]),
      .size      (size_r),
      .result    (load_result_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; IDLE and DONE share the accept path so DONE can retire and accept together.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               if (!is_mem_s || mis_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end else if ((state_r == ST_DONE) && wb_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_REQ: begin
            if (dmem_req_ready) begin
               state_nxt_s = is_store_r ? ST_DONE : ST_WAIT;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (dmem_resp_valid) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Capture the instruction on accept; load data lands in wb_data_r when the response arrives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_r     <= '0;
         size_r     <= 3'd0;
         is_store_r <= 1'b0;
         wdata_r    <= '0;
         wstrb_r    <= 8'h00;
         wb_data_r  <= '0;
         wb_dst_r   <= 5'd0;
         wb_ecall_r <= 1'b0;
         wb_mis_r   <= 1'b0;
      end else if (accept_s) begin
         addr_r     <= ex_res[ADDR_WIDTH-1:0];
         size_r     <= mem_operation_size;
         is_store_r <= is_store_s;
         wdata_r    <= r2_val_mem << {ex_res[2:0], 3'b000};
         wstrb_r    <= lane_mask(mem_operation_size[1:0], ex_res[2:0]);
         wb_ecall_r <= ecall_mem;
         wb_mis_r   <= mis_s;
         if (!is_mem_s) begin
            wb_data_r <= ex_res;
            wb_dst_r  <= mem_dst_reg;
         end else if (is_load_s && !mis_s) begin
            wb_data_r <= '0;
            wb_dst_r  <= mem_dst_reg;
         end else begin
            wb_data_r <= '0;
            wb_dst_r  <= 5'd0;
         end
      end else if ((state_r == ST_WAIT) && dmem_resp_valid) begin
         wb_data_r <= load_result_s;
      end else begin
         wb_data_r <= wb_data_r;
      end
   end

   assign ready          = ready_s;
   assign dmem_req_valid = (state_r == ST_REQ);
   assign dmem_req_addr  = {addr_r[ADDR_WIDTH-1:3], 3'b000};
   assign dmem_req_write = is_store_r;
   assign dmem_req_wdata = wdata_r;
   assign dmem_req_wstrb = wstrb_r;
   assign wb_valid       = (state_r == ST_DONE);
   assign wb_data        = wb_data_r;
   assign wb_dst_reg     = wb_dst_r;
   assign wb_ecall       = wb_ecall_r;
   assign wb_misaligned  = wb_mis_r;

endmodule

// File: tb/tb_pipeline_mem.sv
// Scoreboard bench for pipeline_mem: directed stimulus pushes expected requests and
// write-back results; a negedge monitor pops and compares on every handshake.
module tb_pipeline_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic        ready;
   logic [63:0] ex_res;
   logic [63:0] r2_val_mem;
   logic [4:0]  mem_dst_reg;
   logic [31:0] mem_opcode;
   logic [2:0]  mem_operation_size;
   logic        ecall_mem;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [63:0] dmem_req_addr;
   logic        dmem_req_write;
   logic [63:0] dmem_req_wdata;
   logic [7:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [63:0] dmem_resp_data;
   logic        wb_valid;
   logic        wb_ready;
   logic [63:0] wb_data;
   logic [4:0]  wb_dst_reg;
   logic        wb_ecall;
   logic        wb_misaligned;

   always #5 clk = ~clk;

   pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ready(ready),
      .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
      .mem_opcode(mem_opcode), .mem_operation_size(mem_operation_size), .ecall_mem(ecall_mem),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_addr(dmem_req_addr), .dmem_req_write(dmem_req_write),
      .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
      .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dst_reg(wb_dst_reg),
      .wb_ecall(wb_ecall), .wb_misaligned(wb_misaligned)
   );

   typedef struct {
      logic [63:0] data;
      logic [4:0]  dst;
      logic        ecall;
      logic        mis;
   } wb_exp_t;

   typedef struct {
      logic [63:0] addr;
      logic        write;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } req_exp_t;

   typedef struct {
      logic [63:0] addr;
      logic [2:0]  size;
      logic [63:0] resp;
      logic [63:0] req_addr;
      logic [63:0] result;
   } ld_vec_t;

   typedef struct {
      logic [63:0] addr;
      logic [2:0]  size;
      logic [63:0] r2;
      logic [63:0] req_addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } st_vec_t;

   localparam logic [31:0] OP_NONE  = 32'd0;
   localparam logic [31:0] OP_LOAD  = 32'd1;
   localparam logic [31:0] OP_STORE = 32'd2;

   wb_exp_t  wb_q[$];
   req_exp_t req_q[$];
   wb_exp_t  mon_wb;
   req_exp_t mon_req;
   int n_cmp = 0;
   int n_err = 0;

   ld_vec_t ld_vec [5] = '{
      '{64'h1003, 3'd0, 64'h0000_0000_8000_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_FF80},
      '{64'h1003, 3'd4, 64'h0000_0000_8000_0000, 64'h1000, 64'h0000_0000_0000_0080},
      '{64'h1002, 3'd1, 64'h0000_0000_8000_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_8000},
      '{64'h1008, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h1008, 64'h0123_4567_89AB_CDEF},
      '{64'h1004, 3'd2, 64'h8765_4321_0000_0000, 64'h1000, 64'hFFFF_FFFF_8765_4321}
   };

   st_vec_t st_vec [3] = '{
      '{64'h2006, 3'd1, 64'h1234_5678_9ABC_DEF0, 64'h2000, 64'hDEF0_0000_0000_0000, 8'hC0},
      '{64'h2004, 3'd2, 64'h0000_0000_CAFE_BABE, 64'h2000, 64'hCAFE_BABE_0000_0000, 8'hF0},
      '{64'h2001, 3'd0, 64'h0000_0000_0000_00AB, 64'h2000, 64'h0000_0000_0000_AB00, 8'h02}
   };

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every write-back and memory-request handshake against the queues.
   always @(negedge clk) begin
      if (reset === 1'b1 && wb_valid && wb_ready) begin
         if (wb_q.size() == 0) begin
            check("wb_unexpected", 64'(wb_data), 64'hDEAD);
         end else begin
            mon_wb = wb_q.pop_front();
            check("wb_data", wb_data, mon_wb.data);
            check("wb_dst_reg", 64'(wb_dst_reg), 64'(mon_wb.dst));
            check("wb_ecall", 64'(wb_ecall), 64'(mon_wb.ecall));
            check("wb_misaligned", 64'(wb_misaligned), 64'(mon_wb.mis));
         end
      end
      if (reset === 1'b1 && dmem_req_valid && dmem_req_ready) begin
         if (req_q.size() == 0) begin
            check("req_unexpected", dmem_req_addr, 64'hDEAD);
         end else begin
            mon_req = req_q.pop_front();
            check("req_addr", dmem_req_addr, mon_req.addr);
            check("req_write", 64'(dmem_req_write), 64'(mon_req.write));
            if (mon_req.write) begin
               check("req_wdata", dmem_req_wdata, mon_req.wdata);
               check("req_wstrb", 64'(dmem_req_wstrb), 64'(mon_req.wstrb));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single cycle; caller ensures the stage is ready.
   task automatic issue(input logic [31:0] op, input logic [63:0] res, input logic [63:0] r2,
                        input logic [4:0] dst, input logic [2:0] size, input logic ec);
      ex_valid = 1'b1; mem_opcode = op; ex_res = res; r2_val_mem = r2;
      mem_dst_reg = dst; mem_operation_size = size; ecall_mem = ec;
      tick();
      ex_valid = 1'b0;
   endtask

   task automatic do_load(input ld_vec_t v, input logic [4:0] dst);
      req_q.push_back('{v.req_addr, 1'b0, 64'h0, 8'h00});
      wb_q.push_back('{v.result, dst, 1'b0, 1'b0});
      issue(OP_LOAD, v.addr, 64'h0, dst, v.size, 1'b0);
      check("ld_req_valid", 64'(dmem_req_valid), 64'h1);
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      check("ld_wb_early", 64'(wb_valid), 64'h0);
      dmem_resp_valid = 1'b1; dmem_resp_data = v.resp;
      tick();
      dmem_resp_valid = 1'b0;
      check("ld_wb_valid_n3", 64'(wb_valid), 64'h1);
      tick();
   endtask

   task automatic do_store(input st_vec_t v);
      req_q.push_back('{v.req_addr, 1'b1, v.wdata, v.wstrb});
      wb_q.push_back('{64'h0, 5'd0, 1'b1, 1'b0});
      issue(OP_STORE, v.addr, v.r2, 5'd7, v.size, 1'b1);
      dmem_req_ready = 1'b1;
      check("st_wb_early", 64'(wb_valid), 64'h0);
      tick();
      dmem_req_ready = 1'b0;
      check("st_wb_valid_n2", 64'(wb_valid), 64'h1);
      tick();
   endtask

   initial begin
      reset = 1'b0; ex_valid = 1'b0; ex_res = 64'h0; r2_val_mem = 64'h0; mem_dst_reg = 5'd0;
      mem_opcode = 32'd0; mem_operation_size = 3'd0; ecall_mem = 1'b0;
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = 64'h0; wb_ready = 1'b1;
      #2;
      check("rst_ready", 64'(ready), 64'h1);
      check("rst_wb_valid", 64'(wb_valid), 64'h0);
      check("rst_req_valid", 64'(dmem_req_valid), 64'h0);
      check("rst_req_addr", dmem_req_addr, 64'h0);
      check("rst_req_wstrb", 64'(dmem_req_wstrb), 64'h0);
      check("rst_wb_data", wb_data, 64'h0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // Pass-through, then an unknown opcode treated as none.
      dmem_req_ready = 1'b1;
      wb_q.push_back('{64'h1234, 5'd5, 1'b0, 1'b0});
      issue(OP_NONE, 64'h1234, 64'h0, 5'd5, 3'd0, 1'b0);
      check("pt_wb_valid_n1", 64'(wb_valid), 64'h1);
      check("pt_no_req", 64'(dmem_req_valid), 64'h0);
      tick();
      wb_q.push_back('{64'h55, 5'd2, 1'b1, 1'b0});
      issue(32'd3, 64'h55, 64'h0, 5'd2, 3'd3, 1'b1);
      check("op3_no_req", 64'(dmem_req_valid), 64'h0);
      tick();
      dmem_req_ready = 1'b0;

      for (int i = 0; i < 5; i++) do_load(ld_vec[i], 5'(i + 10));
      for (int i = 0; i < 3; i++) do_store(st_vec[i]);

      // Misaligned word load and half store: no request, flagged result in N+1.
      dmem_req_ready = 1'b1;
      wb_q.push_back('{64'h0, 5'd0, 1'b0, 1'b1});
      issue(OP_LOAD, 64'h1006, 64'h0, 5'd3, 3'd2, 1'b0);
      check("mis_wb_valid_n1", 64'(wb_valid), 64'h1);
      check("mis_no_req", 64'(dmem_req_valid), 64'h0);
      tick();
      wb_q.push_back('{64'h0, 5'd0, 1'b1, 1'b1});
      issue(OP_STORE, 64'h2001, 64'hFFFF, 5'd4, 3'd1, 1'b1);
      check("mis_st_no_req", 64'(dmem_req_valid), 64'h0);
      tick();
      dmem_req_ready = 1'b0;

      // Back-to-back pass-through: retire and accept in the same cycle.
      wb_q.push_back('{64'hA1, 5'd1, 1'b0, 1'b0});
      wb_q.push_back('{64'hB2, 5'd2, 1'b0, 1'b0});
      ex_valid = 1'b1; mem_opcode = OP_NONE; ex_res = 64'hA1; mem_dst_reg = 5'd1; ecall_mem = 1'b0;
      tick();
      check("b2b_ready", 64'(ready), 64'h1);
      ex_res = 64'hB2; mem_dst_reg = 5'd2;
      tick();
      ex_valid = 1'b0;
      check("b2b_second_valid", 64'(wb_valid), 64'h1);
      check("b2b_second_data", wb_data, 64'hB2);
      tick();

      // Backpressure on request then on write-back.
      req_q.push_back('{64'h3000, 1'b0, 64'h0, 8'h00});
      wb_q.push_back('{64'h0000_0000_AABB_CCDD, 5'd9, 1'b0, 1'b0});
      issue(OP_LOAD, 64'h3004, 64'h0, 5'd9, 3'd6, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("bp_req_valid", 64'(dmem_req_valid), 64'h1);
         check("bp_req_addr", dmem_req_addr, 64'h3000);
         check("bp_ready", 64'(ready), 64'h0);
         tick();
      end
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b1; dmem_resp_data = 64'hAABB_CCDD_1122_3344; wb_ready = 1'b0;
      tick();
      dmem_resp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("bp_wb_valid", 64'(wb_valid), 64'h1);
         check("bp_wb_data", wb_data, 64'h0000_0000_AABB_CCDD);
         check("bp_wb_ready_low", 64'(ready), 64'h0);
         tick();
      end
      wb_ready = 1'b1;
      tick();

      // Reset while waiting for a load response; a late response must be ignored.
      req_q.push_back('{64'h4000, 1'b0, 64'h0, 8'h00});
      issue(OP_LOAD, 64'h4000, 64'h0, 5'd6, 3'd3, 1'b1);
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("rstw_wb_valid", 64'(wb_valid), 64'h0);
      check("rstw_req_valid", 64'(dmem_req_valid), 64'h0);
      check("rstw_ready", 64'(ready), 64'h1);
      check("rstw_wb_ecall", 64'(wb_ecall), 64'h0);
      tick();
      reset = 1'b1;
      dmem_resp_valid = 1'b1; dmem_resp_data = 64'h1111_2222_3333_4444;
      tick();
      dmem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_resp_wb_valid", 64'(wb_valid), 64'h0);
         tick();
      end

      check("wb_queue_drained", 64'(wb_q.size()), 64'h0);
      check("req_queue_drained", 64'(req_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
